axi4_lite_master: RTL
=====================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 The block SHALL have parameter ADDRESS_SIZE, default 5, which sets the AXI and command address width.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32, which sets the data width; it is a multiple of 8.
REQ-003 aclk  input  1  single clock; all state changes on the rising edge.
REQ-004 aresetn  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDRESS_SIZE  target address.
REQ-009 cmd_wdata  input  DATA_SIZE  write data.
REQ-010 cmd_wstrb  input  DATA_SIZE/8  write byte strobes.
REQ-011 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-012 rsp_rdata  output  DATA_SIZE  read data; 0 for writes.
REQ-013 rsp_resp  output  2  captured RRESP or BRESP.
REQ-014 rsp_write  output  1  echo of cmd_write.
REQ-015 m_axi_awaddr, m_axi_awvalid, m_axi_awready  out, out, in  ADDRESS_SIZE, 1, 1  AW channel.
REQ-016 m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready  out, out, out, in  DATA_SIZE, DATA_SIZE/8, 1, 1  W channel.
REQ-017 m_axi_bresp, m_axi_bvalid, m_axi_bready  in, in, out  2, 1, 1  B channel.
REQ-018 m_axi_araddr, m_axi_arvalid, m_axi_arready  out, out, in  ADDRESS_SIZE, 1, 1  AR channel.
REQ-019 m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rready  in, in, in, out  DATA_SIZE, 2, 1, 1  R channel.
REQ-020 err_count  output  8  saturating count of responses with resp[1] = 1.

Function
REQ-021 The FSM SHALL have the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP; only one transaction is outstanding at a time.
REQ-022 cmd_ready SHALL be registered and high only in IDLE; on cmd_valid & cmd_ready the block latches addr, wdata, wstrb and write, then goes to WR_REQ (write) or RD_REQ (read).
REQ-023 On entry to WR_REQ, m_axi_awvalid and m_axi_wvalid SHALL both assert on the cycle after command acceptance, with registered, stable address, data and strobe.
REQ-024 awvalid and wvalid SHALL each deassert on the cycle after their own handshake, independently; AW-before-W, W-before-AW and simultaneous completion are all legal.
REQ-025 When both AW and W have completed, the FSM SHALL go to WR_RESP, where m_axi_bready = 1; on bvalid it captures bresp, sets rsp_rdata = 0 and rsp_write = 1, then goes to RSP.
REQ-026 In RD_REQ, m_axi_arvalid = 1 SHALL be held until arready, then the FSM goes to RD_RESP with m_axi_rready = 1; on rvalid it captures rdata and rresp, sets rsp_write = 0, then goes to RSP.
REQ-027 A valid SHALL never drop before its ready, and no valid SHALL depend combinationally on its ready.
REQ-028 bready and rready SHALL be asserted only in WR_RESP and RD_RESP respectively; bvalid or rvalid arriving in any other state is ignored.
REQ-029 In RSP, rsp_valid = 1 SHALL be held with stable outputs until rsp_ready, then the FSM returns to IDLE with cmd_ready = 1 on the following cycle.
REQ-030 Minimum command-to-rsp_valid latency SHALL be 3 cycles when ready/valid are immediately available on every channel; back-to-back throughput is one transaction per 4 cycles minimum.
REQ-031 err_count SHALL increment on each capture with resp[1] = 1 (SLVERR/DECERR) and saturate at 255.

Reset
REQ-032 While aresetn = 0, all of the following SHALL be 0: cmd_ready, rsp_valid, all m_axi_*valid, bready, rready, err_count, rsp_* and m_axi address/data/strobe outputs; the FSM is forced to IDLE.
REQ-033 A reset asserted mid-transaction SHALL discard the transaction with no response; cmd_ready rises on the first aclk edge after release.

Verification
REQ-034 Write 0x0C, data 0xDEADBEEF, strb 0xF, with all slave readies and bvalid = 1, bresp = 0 -> awvalid/wvalid high 1 cycle, rsp_valid at cycle 3, rsp_resp = 0, rsp_write = 1.
REQ-035 Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles with addr stable, single B handshake.
REQ-036 Read 0x10 with rdata = 0x12345678, rresp = 0, rready held while rvalid is withheld 3 cycles -> rsp_rdata = 0x12345678, rsp_write = 0.
REQ-037 300 reads with rresp = 2'b10 -> err_count = 255 at end; a read with rresp = 0 leaves it 255.
REQ-038 rsp_ready held low 5 cycles -> rsp_valid and rsp data stable, cmd_ready low throughout.
REQ-039 aresetn pulsed low in WR_RESP -> valids and readies 0 immediately, no rsp_valid, next command completes normally.

Source files
------------

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite master that turns a simple
// command/response handshake into AW/W/B or AR/R channel transactions.
module axi4_lite_master #(
   parameter int ADDRESS_SIZE = 5,
   parameter int DATA_SIZE    = 32
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   // command / response side
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDRESS_SIZE-1:0]   cmd_addr,
   input  logic [DATA_SIZE-1:0]      cmd_wdata,
   input  logic [DATA_SIZE/8-1:0]    cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_SIZE-1:0]      rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_write,
   // AW channel
   output logic [ADDRESS_SIZE-1:0]   m_axi_awaddr,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   // W channel
   output logic [DATA_SIZE-1:0]      m_axi_wdata,
   output logic [DATA_SIZE/8-1:0]    m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   // B channel
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   // AR channel
   output logic [ADDRESS_SIZE-1:0]   m_axi_araddr,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   // R channel
   input  logic [DATA_SIZE-1:0]      m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic [7:0]                err_count
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;

   logic                      r_cmd_ready;
   logic                      r_rsp_valid;
   logic                      r_bready;
   logic                      r_rready;
   logic                      r_awvalid;
   logic                      r_wvalid;
   logic                      r_arvalid;
   logic [ADDRESS_SIZE-1:0]   r_addr;
   logic [DATA_SIZE-1:0]      r_wdata;
   logic [DATA_SIZE/8-1:0]    r_wstrb;
   logic                      r_write;
   logic [DATA_SIZE-1:0]      r_rsp_rdata;
   logic [1:0]                r_rsp_resp;
   logic                      r_rsp_write;
   logic [7:0]                r_err_count;

   logic                      w_cmd_fire;
   logic                      w_aw_fire;
   logic                      w_w_fire;
   logic                      w_ar_fire;
   logic                      w_b_fire;
   logic                      w_r_fire;
   logic                      w_capture;
   logic [1:0]                w_capture_resp;
   logic                      w_wr_req_done;

   assign w_cmd_fire     = cmd_valid & r_cmd_ready;
   assign w_aw_fire      = r_awvalid & m_axi_awready;
   assign w_w_fire       = r_wvalid  & m_axi_wready;
   assign w_ar_fire      = r_arvalid & m_axi_arready;
   assign w_b_fire       = r_bready  & m_axi_bvalid;
   assign w_r_fire       = r_rready  & m_axi_rvalid;
   assign w_capture      = w_b_fire | w_r_fire;
   assign w_capture_resp = w_b_fire ? m_axi_bresp : m_axi_rresp;

   // A write channel is finished once its valid already dropped or it handshakes now.
   assign w_wr_req_done  = (~r_awvalid | m_axi_awready) & (~r_wvalid | m_axi_wready);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_cmd_fire)     w_next_state = cmd_write ? WR_REQ : RD_REQ;
         WR_REQ:  if (w_wr_req_done)  w_next_state = WR_RESP;
         WR_RESP: if (m_axi_bvalid)   w_next_state = RSP;
         RD_REQ:  if (m_axi_arready)  w_next_state = RD_RESP;
         RD_RESP: if (m_axi_rvalid)   w_next_state = RSP;
         RSP:     if (rsp_ready)      w_next_state = IDLE;
         default:                     w_next_state = IDLE;
      endcase
   end

   // Handshake outputs are decoded from the next state so each one leaves a flop.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= IDLE;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_bready    <= 1'b0;
         r_rready    <= 1'b0;
      end else begin
         // NOTE: non-blocking, so every flop samples the pre-edge values of the others.
         r_state     <= w_next_state;
         r_cmd_ready <= (w_next_state == IDLE);
         r_rsp_valid <= (w_next_state == RSP);
         r_bready    <= (w_next_state == WR_RESP);
         r_rready    <= (w_next_state == RD_RESP);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_write     <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
         r_rsp_write <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         if (w_cmd_fire) begin
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_write   <= cmd_write;
            r_awvalid <= cmd_write;
            r_wvalid  <= cmd_write;
            r_arvalid <= ~cmd_write;
         end else begin
            if (w_aw_fire) r_awvalid <= 1'b0;
            if (w_w_fire)  r_wvalid  <= 1'b0;
            if (w_ar_fire) r_arvalid <= 1'b0;
         end

         if (w_capture) begin
            r_rsp_resp  <= w_capture_resp;
            r_rsp_rdata <= w_b_fire ? '0 : m_axi_rdata;
            r_rsp_write <= r_write;
            // SLVERR and DECERR both have resp[1] set; the count sticks at 255.
            if (w_capture_resp[1] && (r_err_count != 8'hFF))
               r_err_count <= r_err_count + 8'd1;
         end
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign rsp_write     = r_rsp_write;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;
   assign err_count     = r_err_count;

endmodule
